// File: rtl/req_capture_4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : req_capture_4
// Purpose  : Request capture front-end for a 4-to-2 priority encoder.
//            Synchronises four asynchronous request lines and detects their
//            rising edges. Each event is held as a sticky pending bit, and the
//            pending vector is presented to the encoder. The encoded index is
//            captured and offered downstream over a valid/ready handshake.
//            Events that hit an already-pending bit are counted as lost.
// Revision : 1.0  initial release
// ============================================================================
module req_capture_4 #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req_in,
   output logic [3:0]       pend_o,
   input  logic [1:0]       enc_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_idx,
   output logic [CNT_W-1:0] ovf_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t                          state;
   state_t                          state_nxt;
   logic                            capture;
   logic                            accept;

   logic [SYNC_STAGES-1:0][3:0]     sync_q;
   logic [3:0]                      req_s;
   logic [3:0]                      req_d;
   logic [3:0]                      rise;
   logic [3:0]                      clr;
   logic [3:0]                      lost;

   // Synchroniser chains: shift raw requests through SYNC_STAGES flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // Edge register: synchronised level delayed one cycle for rise detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_d <= '0;
      end else begin
         req_d <= req_s;
      end
   end

   // A held level yields one event; clearing only happens on a real handshake
   assign rise   = req_s & ~req_d;
   assign accept = (state == OFFER) & out_ready;
   assign clr    = accept ? (4'b0001 << out_idx) : 4'b0000;
   assign lost   = rise & pend_o & ~clr;

   // Pending bits: clear the served bit, then OR in new events so set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_o <= '0;
      end else begin
         pend_o <= (pend_o & ~clr) | rise;
      end
   end

   // Lost-event counter: one increment per cycle with any loss, saturating
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt <= '0;
      end else if ((lost != 4'b0000) && (ovf_cnt != {CNT_W{1'b1}})) begin
         ovf_cnt <= ovf_cnt + CNT_ONE;
      end
   end

   // Served index: sampled from the encoder only when arbitrating in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_idx <= 2'd0;
      end else if (capture) begin
         out_idx <= enc_idx;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and outputs; GAP lets the encoder see the updated vector
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (pend_o != 4'b0000) begin
               capture   = 1'b1;
               state_nxt = OFFER;
            end
         end
         OFFER: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
